// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
//
// N-channel push-button debouncer. Every channel runs on its own: a 2-flop
// synchroniser, then a 4-state filter FSM with a shared debounce/hold counter.
// Each channel reports its debounced pin level and one-cycle pulses for press,
// release, level change and long press. Downstream logic therefore needs no
// edge detection or hold timers of its own.
//
// Parameters
//   N_KEYS      number of independent channels (1..32)
//   DB_CYCLES   stable cycles needed to accept a level change (>= 2)
//   LONG_CYCLES cycles of debounced press before key_long fires (> DB_CYCLES)
//   ACTIVE_LOW  1: pressed pin reads 0, idle pin reads 1; 0: the inverse
//
// Ports
//   sys_clk      system clock
//   sys_rst_n    asynchronous active-low reset
//   key          raw asynchronous key pins
//   key_value    debounced pin level, same polarity as the pin
//   key_flag     one-cycle pulse whenever key_value changes
//   key_press    one-cycle pulse on a debounced press
//   key_release  one-cycle pulse on a debounced release
//   key_long     one-cycle pulse, at most once per press, after LONG_CYCLES
// -----------------------------------------------------------------------------
module key_debounce_multi #(
  parameter int N_KEYS      = 4,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 50_000_000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_value,
  output logic [N_KEYS-1:0] key_flag,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  // The counter must reach LONG_CYCLES-1. It is derived here and is not
  // meant to be overridden.
  localparam int CNT_W = $clog2(LONG_CYCLES + 1);

  localparam logic              IDLE_LVL  = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic              PRESS_LVL = ~IDLE_LVL;
  localparam logic [N_KEYS-1:0] IDLE_VEC  = {N_KEYS{IDLE_LVL}};
  localparam logic [N_KEYS-1:0] ZERO_VEC  = {N_KEYS{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED   = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_DB_RELEASE = 2'd3
  } state_t;

  logic [N_KEYS-1:0] sync1_r;
  logic [N_KEYS-1:0] sync2_r;
  logic [N_KEYS-1:0] act_s;

  state_t            state_r     [N_KEYS];
  state_t            state_nxt_s [N_KEYS];
  logic [CNT_W-1:0]  cnt_r       [N_KEYS];
  logic [CNT_W-1:0]  cnt_nxt_s   [N_KEYS];
  logic [N_KEYS-1:0] long_done_r;
  logic [N_KEYS-1:0] long_done_nxt_s;

  logic [N_KEYS-1:0] value_nxt_s;
  logic [N_KEYS-1:0] press_nxt_s;
  logic [N_KEYS-1:0] release_nxt_s;
  logic [N_KEYS-1:0] long_nxt_s;

  // Two-flop synchroniser. It resets to the idle pin level, so leaving
  // reset never looks like an edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_r <= IDLE_VEC;
      sync2_r <= IDLE_VEC;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
    end
  end

  // Normalise the polarity so that act_s = 1 means "pressed" on every channel.
  assign act_s = sync2_r ^ IDLE_VEC;

  // Per-channel FSM state, counter and long-press latch.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_r[i] <= ST_RELEASED;
        cnt_r[i]   <= CNT_ZERO;
      end
      long_done_r <= ZERO_VEC;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_r[i] <= state_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
      end
      long_done_r <= long_done_nxt_s;
    end
  end

  // Next-state, counter and pulse decode for every channel.
  always_comb begin
    long_done_nxt_s = long_done_r;
    value_nxt_s     = key_value;
    press_nxt_s     = ZERO_VEC;
    release_nxt_s   = ZERO_VEC;
    long_nxt_s      = ZERO_VEC;
    for (int i = 0; i < N_KEYS; i++) begin
      state_nxt_s[i] = state_r[i];
      cnt_nxt_s[i]   = cnt_r[i];
      case (state_r[i])
        ST_RELEASED: begin
          if (act_s[i]) begin
            state_nxt_s[i] = ST_DB_PRESS;
            cnt_nxt_s[i]   = CNT_ZERO;
          end else begin
            state_nxt_s[i] = ST_RELEASED;
          end
        end
        ST_DB_PRESS: begin
          if (!act_s[i]) begin
            // A bounce: drop back silently.
            state_nxt_s[i] = ST_RELEASED;
          end else if (cnt_r[i] == DB_LAST) begin
            state_nxt_s[i]     = ST_PRESSED;
            cnt_nxt_s[i]       = CNT_ZERO;
            long_done_nxt_s[i] = 1'b0;
            press_nxt_s[i]     = 1'b1;
            value_nxt_s[i]     = PRESS_LVL;
          end else begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!act_s[i]) begin
            state_nxt_s[i] = ST_DB_RELEASE;
            cnt_nxt_s[i]   = CNT_ZERO;
          end else if (!long_done_r[i] && (cnt_r[i] == LONG_LAST)) begin
            long_nxt_s[i]      = 1'b1;
            long_done_nxt_s[i] = 1'b1;
          end else if (cnt_r[i] < LONG_LAST) begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
          end else begin
            // The hold timer saturates once the long press is reported.
            cnt_nxt_s[i] = cnt_r[i];
          end
        end
        ST_DB_RELEASE: begin
          if (act_s[i]) begin
            // A release glitch: the hold timer restarts, but long_done is
            // kept so key_long cannot fire twice in one press.
            state_nxt_s[i] = ST_PRESSED;
            cnt_nxt_s[i]   = CNT_ZERO;
          end else if (cnt_r[i] == DB_LAST) begin
            state_nxt_s[i]   = ST_RELEASED;
            cnt_nxt_s[i]     = CNT_ZERO;
            release_nxt_s[i] = 1'b1;
            value_nxt_s[i]   = IDLE_LVL;
          end else begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s[i] = ST_RELEASED;
          cnt_nxt_s[i]   = CNT_ZERO;
        end
      endcase
    end
  end

  // Registered outputs. key_flag comes from the same decode as press and
  // release, so the three outputs always agree.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_value   <= IDLE_VEC;
      key_flag    <= ZERO_VEC;
      key_press   <= ZERO_VEC;
      key_release <= ZERO_VEC;
      key_long    <= ZERO_VEC;
    end else begin
      key_value   <= value_nxt_s;
      key_flag    <= press_nxt_s | release_nxt_s;
      key_press   <= press_nxt_s;
      key_release <= release_nxt_s;
      key_long    <= long_nxt_s;
    end
  end

endmodule
